// File: rtl/stack_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_alu_pkg
//  Description : Shared opcodes and FSM state encoding for the stack ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_alu_pkg;

    // Command opcodes; 1001..1111 are undefined and raise err_opcode
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUSH = 4'd1;
    localparam logic [3:0] OP_POP  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_DUP  = 4'd6;
    localparam logic [3:0] OP_SWAP = 4'd7;
    localparam logic [3:0] OP_CLR  = 4'd8;

    // Control FSM: single-cycle ops stay in IDLE, MUL parks in MUL_RUN
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mul_signed.sv
`default_nettype none
// ============================================================================
//  Module      : seq_mul_signed
//  Description : Iterative signed multiplier. Shift-add on operand magnitudes,
//                sign applied to the result. The first step is folded into the
//                load so done rises exactly N cycles after start is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_mul_signed #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;

    logic [N-1:0]  r_hi;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_mcand;
    logic          r_neg;
    logic          r_busy;
    logic [CW-1:0] r_cnt;

    logic [N-1:0]  w_a_mag;
    logic [N-1:0]  w_b_mag;
    logic [N:0]    w_load_sum;
    logic [N:0]    w_step_sum;
    logic [2*N-1:0] w_mag_prod;

    // Magnitudes: -2^(N-1) maps to 2^(N-1), which still fits unsigned in N bits
    assign w_a_mag    = a[N-1] ? (~a + 1'b1) : a;
    assign w_b_mag    = b[N-1] ? (~b + 1'b1) : b;
    assign w_load_sum = {1'b0, (w_b_mag[0] ? w_a_mag : {N{1'b0}})};
    assign w_step_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : {N{1'b0}})};
    assign w_mag_prod = {r_hi, r_lo};

    assign done    = r_busy && (r_cnt == CW'(N - 1));
    assign product = r_neg ? (~w_mag_prod + 1'b1) : w_mag_prod;

    // Load performs step 0, then one add-and-shift per cycle until step N-1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
            r_neg   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mcand <= w_a_mag;
            r_neg   <= a[N-1] ^ b[N-1];
            r_hi    <= w_load_sum[N:1];
            r_lo    <= {w_load_sum[0], w_b_mag[N-1:1]};
        end else if (r_busy) begin
            if (r_cnt == CW'(N - 1)) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_hi  <= w_step_sum[N:1];
                r_lo  <= {w_step_sum[0], r_lo[N-1:1]};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stack_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : stack_alu_pipe
//  Description : Signed operand stack with ALU ops, valid/ready command input,
//                per-command error flags and a multi-cycle MUL.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_alu_pipe
    import stack_alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             overflow,
    output logic             err_underflow,
    output logic             err_full,
    output logic             err_opcode,
    output logic [PTR_W:0]   sp,
    output logic             empty,
    output logic             full
);

    localparam int SW = PTR_W + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_stack [DEPTH];
    logic [SW-1:0]    r_sp;
    logic [N-1:0]     r_out_data;
    logic             r_out_valid;
    logic             r_ovf, r_eu, r_ef, r_eo;

    logic             w_in_ready, w_accept, w_full, w_ge1, w_ge2;
    logic [SW-1:0]    w_sp_m1, w_sp_m2;
    logic [PTR_W-1:0] w_ptr_push, w_ptr_top, w_ptr_sec;
    logic [N-1:0]     w_t, w_s, w_sum, w_diff;
    logic             w_ovf_add, w_ovf_sub;
    logic             w_mul_start, w_mul_done, w_mul_ovf;
    logic [2*N-1:0]   w_prod;

    logic             w_wr0_en, w_wr1_en;
    logic [PTR_W-1:0] w_wr0_idx, w_wr1_idx;
    logic [N-1:0]     w_wr0_dat, w_wr1_dat;
    logic [SW-1:0]    w_sp_nxt;
    logic             w_res_vld, w_flag_ld;
    logic [N-1:0]     w_res;
    logic             w_ovf, w_eu, w_ef, w_eo;

    assign w_accept   = in_valid && w_in_ready;
    assign w_full     = (r_sp == SW'(DEPTH));
    assign w_ge1      = (r_sp != '0);
    assign w_ge2      = (r_sp >= SW'(2));
    assign w_sp_m1    = r_sp - SW'(1);
    assign w_sp_m2    = r_sp - SW'(2);
    assign w_ptr_push = r_sp[PTR_W-1:0];
    assign w_ptr_top  = w_sp_m1[PTR_W-1:0];
    assign w_ptr_sec  = w_sp_m2[PTR_W-1:0];
    assign w_t        = r_stack[w_ptr_top];
    assign w_s        = r_stack[w_ptr_sec];
    assign w_sum      = w_s + w_t;
    assign w_diff     = w_s - w_t;
    assign w_ovf_add  = (w_s[N-1] == w_t[N-1]) && (w_sum[N-1]  != w_s[N-1]);
    assign w_ovf_sub  = (w_s[N-1] != w_t[N-1]) && (w_diff[N-1] != w_s[N-1]);
    assign w_mul_start = w_accept && (opcode == OP_MUL) && w_ge2;
    // Truncated product is exact only when the upper N+1 bits are a sign extension
    assign w_mul_ovf  = !((&w_prod[2*N-1:N-1]) || !(|w_prod[2*N-1:N-1]));

    seq_mul_signed #(.N(N)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_s),
        .b       (w_t),
        .done    (w_mul_done),
        .product (w_prod)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next state: MUL_RUN holds until the multiplier reports done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_mul_start) w_state_nxt = ST_MUL_RUN;
            ST_MUL_RUN: if (w_mul_done)  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: commands are only taken in IDLE
    always_comb begin
        w_in_ready = (r_state == ST_IDLE);
    end

    // Command decode: stack writes, pointer update, result and flag values
    always_comb begin
        w_wr0_en  = 1'b0;  w_wr0_idx = w_ptr_push; w_wr0_dat = in_data;
        w_wr1_en  = 1'b0;  w_wr1_idx = w_ptr_sec;  w_wr1_dat = w_t;
        w_sp_nxt  = r_sp;  w_res_vld = 1'b0;       w_res     = w_sum;
        w_flag_ld = 1'b0;  w_ovf = 1'b0; w_eu = 1'b0; w_ef = 1'b0; w_eo = 1'b0;
        if (r_state == ST_MUL_RUN) begin
            if (w_mul_done) begin
                w_wr0_en  = 1'b1; w_wr0_idx = w_ptr_sec; w_wr0_dat = w_prod[N-1:0];
                w_sp_nxt  = w_sp_m1;
                w_res_vld = 1'b1; w_res = w_prod[N-1:0];
                w_flag_ld = 1'b1; w_ovf = w_mul_ovf;
            end
        end else if (w_accept) begin
            w_flag_ld = 1'b1;
            case (opcode)
                OP_NOP: ;
                OP_PUSH: begin
                    if (w_full) w_ef = 1'b1;
                    else begin w_wr0_en = 1'b1; w_sp_nxt = r_sp + SW'(1); end
                end
                OP_POP: begin
                    if (!w_ge1) w_eu = 1'b1;
                    else begin w_res_vld = 1'b1; w_res = w_t; w_sp_nxt = w_sp_m1; end
                end
                OP_ADD, OP_SUB: begin
                    if (!w_ge2) w_eu = 1'b1;
                    else begin
                        w_res     = (opcode == OP_ADD) ? w_sum : w_diff;
                        w_ovf     = (opcode == OP_ADD) ? w_ovf_add : w_ovf_sub;
                        w_wr0_en  = 1'b1; w_wr0_idx = w_ptr_sec; w_wr0_dat = w_res;
                        w_sp_nxt  = w_sp_m1; w_res_vld = 1'b1;
                    end
                end
                OP_MUL:  if (!w_ge2) w_eu = 1'b1;
                OP_DUP: begin
                    if (!w_ge1)      w_eu = 1'b1;
                    else if (w_full) w_ef = 1'b1;
                    else begin
                        w_wr0_en = 1'b1; w_wr0_dat = w_t; w_sp_nxt = r_sp + SW'(1);
                    end
                end
                OP_SWAP: begin
                    if (!w_ge2) w_eu = 1'b1;
                    else begin
                        w_wr0_en = 1'b1; w_wr0_idx = w_ptr_top; w_wr0_dat = w_s;
                        w_wr1_en = 1'b1;
                    end
                end
                OP_CLR:  w_sp_nxt = '0;
                default: w_eo = 1'b1;
            endcase
        end
    end

    // Stack storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (w_wr0_en) r_stack[w_wr0_idx] <= w_wr0_dat;
        if (w_wr1_en) r_stack[w_wr1_idx] <= w_wr1_dat;
    end

    // Architectural registers: pointer, result, status flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sp        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
            r_eu        <= 1'b0;
            r_ef        <= 1'b0;
            r_eo        <= 1'b0;
        end else begin
            r_sp        <= w_sp_nxt;
            r_out_valid <= w_res_vld;
            if (w_res_vld) r_out_data <= w_res;
            if (w_flag_ld) begin
                r_ovf <= w_ovf;
                r_eu  <= w_eu;
                r_ef  <= w_ef;
                r_eo  <= w_eo;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign overflow      = r_ovf;
    assign err_underflow = r_eu;
    assign err_full      = r_ef;
    assign err_opcode    = r_eo;
    assign sp            = r_sp;
    assign empty         = (r_sp == '0);
    assign full          = w_full;

endmodule
`default_nettype wire

// File: tb/tb_stack_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_alu_pipe
//  Description : Self-checking bench: queue-based stack model compared every
//                cycle, directed scenarios with literal results, random mix.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_alu_pipe;

    localparam int N     = 32;
    localparam int DEPTH = 32;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, overflow, err_underflow, err_full, err_opcode;
    logic        empty, full;
    logic [31:0] out_data;
    logic [5:0]  sp;

    int n_chk  = 0;
    int n_pass = 0;

    stack_alu_pipe #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .in_data(in_data), .out_valid(out_valid),
        .out_data(out_data), .overflow(overflow), .err_underflow(err_underflow),
        .err_full(err_full), .err_opcode(err_opcode), .sp(sp),
        .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    logic signed [31:0] stk[$];
    logic [31:0] m_out = '0;
    logic        m_valid = 0, m_ovf = 0, m_eu = 0, m_ef = 0, m_eo = 0, m_busy = 0;
    int          m_cnt = 0;
    logic signed [31:0] m_a, m_b;

    always @(posedge clk or negedge rst) begin
        logic signed [31:0] s, t, r;
        longint w;
        if (!rst) begin
            stk.delete();
            m_out = '0; m_valid = 0; m_ovf = 0; m_eu = 0; m_ef = 0; m_eo = 0;
            m_busy = 0; m_cnt = 0;
        end else begin
            m_valid = 0;
            if (m_busy) begin
                m_cnt++;
                if (m_cnt == N) begin
                    w = longint'(m_a) * longint'(m_b);
                    r = w[31:0];
                    void'(stk.pop_back()); void'(stk.pop_back());
                    stk.push_back(r);
                    m_ovf = (w > MAXI) || (w < MINI);
                    m_out = r; m_valid = 1; m_busy = 0;
                end
            end else if (in_valid) begin
                m_ovf = 0; m_eu = 0; m_ef = 0; m_eo = 0;
                case (opcode)
                    4'd0: ;
                    4'd1: if (stk.size() == DEPTH) m_ef = 1; else stk.push_back(in_data);
                    4'd2: if (stk.size() < 1) m_eu = 1;
                          else begin m_out = stk.pop_back(); m_valid = 1; end
                    4'd3, 4'd4: if (stk.size() < 2) m_eu = 1;
                          else begin
                              t = stk.pop_back(); s = stk.pop_back();
                              w = (opcode == 4'd3) ? longint'(s) + longint'(t)
                                                   : longint'(s) - longint'(t);
                              r = w[31:0];
                              m_ovf = (w > MAXI) || (w < MINI);
                              stk.push_back(r); m_out = r; m_valid = 1;
                          end
                    4'd5: if (stk.size() < 2) m_eu = 1;
                          else begin
                              m_a = stk[stk.size()-2]; m_b = stk[stk.size()-1];
                              m_busy = 1; m_cnt = 0;
                          end
                    4'd6: if (stk.size() < 1) m_eu = 1;
                          else if (stk.size() == DEPTH) m_ef = 1;
                          else stk.push_back(stk[stk.size()-1]);
                    4'd7: if (stk.size() < 2) m_eu = 1;
                          else begin
                              t = stk[stk.size()-1];
                              stk[stk.size()-1] = stk[stk.size()-2];
                              stk[stk.size()-2] = t;
                          end
                    4'd8: stk.delete();
                    default: m_eo = 1;
                endcase
            end
        end
    end

    // Every cycle out of reset: DUT outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready",  {31'd0, in_ready},      {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid},     {31'd0, m_valid});
            chk("out_data",  out_data,               m_out);
            chk("overflow",  {31'd0, overflow},      {31'd0, m_ovf});
            chk("err_under", {31'd0, err_underflow}, {31'd0, m_eu});
            chk("err_full",  {31'd0, err_full},      {31'd0, m_ef});
            chk("err_op",    {31'd0, err_opcode},    {31'd0, m_eo});
            chk("sp",        {26'd0, sp},            32'(stk.size()));
            chk("empty",     {31'd0, empty},         {31'd0, stk.size() == 0});
            chk("full",      {31'd0, full},          {31'd0, stk.size() == DEPTH});
        end
    end

    // ---------------- stimulus ----------------
    task automatic cmd(input logic [3:0] op, input logic [31:0] d);
        int t = 0;
        while (!in_ready && t < 200) begin @(negedge clk); t++; end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; opcode = op; in_data = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_mul(output int lowc);
        lowc = 0;
        while (!in_ready && lowc < 100) begin lowc++; @(negedge clk); end
    endtask

    initial begin
        int lowc, pulses;
        logic [31:0] last, v, r;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_sp", {26'd0, sp}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out", out_data, 32'd0);

        // basic add
        cmd(4'd1, 32'd5); cmd(4'd1, 32'd7); cmd(4'd3, 0);
        chk("add_out", out_data, 32'd12);
        chk("add_vld", {31'd0, out_valid}, 32'd1);
        chk("add_sp", {26'd0, sp}, 32'd1);
        chk("add_ovf", {31'd0, overflow}, 32'd0);

        // signed overflow, both directions
        cmd(4'd8, 0);
        cmd(4'd1, 32'h7FFF_FFFF); cmd(4'd1, 32'd1); cmd(4'd3, 0);
        chk("addov_out", out_data, 32'h8000_0000);
        chk("addov_ovf", {31'd0, overflow}, 32'd1);
        cmd(4'd1, 32'd3); cmd(4'd4, 0);
        chk("subov_out", out_data, 32'h7FFF_FFFD);
        chk("subov_ovf", {31'd0, overflow}, 32'd1);

        // multiply: latency, sign, overflow
        cmd(4'd8, 0);
        cmd(4'd1, -32'sd3); cmd(4'd1, 32'd4); cmd(4'd5, 0);
        wait_mul(lowc);
        chk("mul_busy", 32'(lowc), 32'd32);
        chk("mul_vld", {31'd0, out_valid}, 32'd1);
        chk("mul_out", out_data, 32'hFFFF_FFF4);
        chk("mul_ovf", {31'd0, overflow}, 32'd0);
        chk("mul_sp", {26'd0, sp}, 32'd1);
        cmd(4'd1, 32'h0001_0000); cmd(4'd6, 0); cmd(4'd5, 0);
        wait_mul(lowc);
        chk("mulov_out", out_data, 32'd0);
        chk("mulov_ovf", {31'd0, overflow}, 32'd1);

        // swap, pop, underflow
        cmd(4'd8, 0);
        cmd(4'd1, 32'd10); cmd(4'd1, 32'd3); cmd(4'd7, 0); cmd(4'd4, 0);
        chk("swsub_out", out_data, 32'hFFFF_FFF9);
        chk("swsub_sp", {26'd0, sp}, 32'd1);
        cmd(4'd2, 0);
        chk("pop_out", out_data, 32'hFFFF_FFF9);
        chk("pop_sp", {26'd0, sp}, 32'd0);
        cmd(4'd2, 0);
        chk("popu_err", {31'd0, err_underflow}, 32'd1);
        chk("popu_vld", {31'd0, out_valid}, 32'd0);

        // fill, overfill, bad opcode
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin v = $urandom; last = v; cmd(4'd1, v); end
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_sp", {26'd0, sp}, 32'd32);
        cmd(4'd1, 32'd123);
        chk("ovfl_err", {31'd0, err_full}, 32'd1);
        chk("ovfl_sp", {26'd0, sp}, 32'd32);
        cmd(4'hF, 0);
        chk("badop_err", {31'd0, err_opcode}, 32'd1);
        chk("badop_full", {31'd0, err_full}, 32'd0);
        cmd(4'd2, 0);
        chk("top_kept", out_data, last);

        // reset in the middle of a multiply
        cmd(4'd8, 0);
        cmd(4'd1, 32'd2); cmd(4'd1, 32'd2); cmd(4'd5, 0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_sp", {26'd0, sp}, 32'd0);
        chk("abort_vld", {31'd0, out_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (out_valid) pulses++; end
        chk("abort_pulse", 32'(pulses), 32'd0);

        // random mix, checked cycle by cycle against the model
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            v = (r[0]) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
            if (r < 35)      cmd(4'd1, v);
            else if (r < 43) cmd(4'd5, v);
            else             cmd(4'($urandom_range(0, 15)), v);
        end
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stack_alu_pipe.md
Name: stack_alu_pipe

Overview:
- Parametrised next-generation stack ALU: an N-bit signed operand stack with DEPTH entries, driven by an in_valid/in_ready command handshake.
- Arithmetic ops are true stack ops: pop two operands, push the result.
- MUL runs on an iterative multi-cycle multiplier; all other ops complete in one cycle.
- Sits between the command sequencer and the result consumer; reports per-command error status.

Parameters:
- N, 32, operand/result width in bits (signed two's complement).
- DEPTH, 32, stack entries; any value >= 2.
- PTR_W, $clog2(DEPTH), index width; sp is PTR_W+1 bits so 0..DEPTH is representable.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command.
- opcode  in  4  command code, sampled on accept.
- in_data  in  N  signed PUSH operand.
- out_valid  out  1  one-cycle pulse: out_data holds a new result.
- out_data  out  N  signed result or popped value; holds between pulses.
- overflow  out  1  signed overflow of the last accepted ADD/SUB/MUL.
- err_underflow  out  1  last accepted command lacked operands.
- err_full  out  1  last accepted command would exceed DEPTH.
- err_opcode  out  1  last accepted opcode undefined.
- sp  out  PTR_W+1  current entry count.
- empty  out  1  sp==0 (combinational).
- full  out  1  sp==DEPTH (combinational).

Behaviour:
- Reset (rst=0, async): FSM to IDLE; sp=0; out_data=0; out_valid=0; overflow and all err flags 0; in_ready=1 once released. Stack RAM is not cleared. Reset during MUL aborts it: no writeback, no out_valid.
- Accept: in_valid && in_ready at a rising edge (edge E0). in_ready=1 only in IDLE.
- Flags: overflow and err_* are recomputed on every accepted command, cleared if not applicable. A failed command changes neither the stack nor sp and gives no out_valid.
- Notation: T = stack[sp-1] (top), S = stack[sp-2].
- 0000 NOP: no state change; flags cleared.
- 0001 PUSH: if !full, stack[sp]=in_data, sp+1; else err_full.
- 0010 POP: if sp>=1, out_data=T, out_valid, sp-1; else err_underflow.
- 0011 ADD: if sp>=2, R=S+T; write R at sp-2, sp-1, out_data=R, out_valid; else err_underflow.
- 0100 SUB: same as ADD with R=S-T.
- ADD/SUB overflow: operands same sign (ADD) or opposite sign (SUB) and R's sign differs from S.
- 0101 MUL: if sp>=2, latch S and T at E0, go to MUL_RUN, in_ready=0. Iterative signed multiply takes N cycles. At edge E0+N: write R=product[N-1:0] at sp-2, sp-1, out_data=R, out_valid high for that cycle, return to IDLE (in_ready high in the same cycle). overflow=1 if product[2N-1:N-1] is not all-equal. If sp<2: err_underflow, single cycle, no MUL_RUN.
- 0110 DUP: needs sp>=1 (else err_underflow) and !full (else err_full; underflow takes priority). Pushes T; no out_valid.
- 0111 SWAP: needs sp>=2 (else err_underflow); exchanges T and S; no out_valid.
- 1000 CLR: sp=0; no out_valid.
- 1001-1111: err_opcode; no state change.
- Single-cycle results: out_valid and the new out_data are visible the cycle after E0. There is no output backpressure.
- FSM: IDLE -> MUL_RUN on accepted MUL with sp>=2. MUL_RUN -> IDLE when the cycle counter reaches N-1. Reset -> IDLE from any state.

Decomposition:
- Shared package stack_alu_pkg: opcode localparams (OP_NOP..OP_CLR), FSM state enum.
- Sub-module seq_mul_signed (params N): inputs start, a, b; outputs done, 2N-bit product. Shift-add on magnitudes with sign correction; done after exactly N cycles.

Test Plan:
- PUSH 5, PUSH 7, ADD -> out_data=12, out_valid one cycle after accept, sp=1, overflow=0.
- PUSH 0x7FFFFFFF, PUSH 1, ADD -> out_data=0x80000000, overflow=1; then PUSH 3, SUB (0x80000000-3) -> 0x7FFFFFFD, overflow=1.
- PUSH -3, PUSH 4, MUL -> in_ready low 32 cycles, out_data=-12 (0xFFFFFFF4), overflow=0, sp=1; then PUSH 0x10000, DUP, MUL -> out_data=0, overflow=1.
- PUSH 10, PUSH 3, SWAP, SUB -> out_data=-7, sp=1; then POP -> out_data=-7, sp=0; then POP -> err_underflow=1, sp=0, no out_valid.
- 32 PUSHes -> full=1, sp=32; 33rd PUSH -> err_full=1, sp=32, top unchanged; opcode 1111 -> err_opcode=1 and err_full cleared.
- PUSH 2, PUSH 2, MUL, assert rst=0 at cycle 10 of MUL_RUN -> immediately sp=0, in_ready=1 after release, no out_valid pulse.
